// File: rtl/axi2fifo_param.sv
// axi2fifo_param: AXI4-Stream slave to SRAM output-queue FIFO stage.
// The first beat of each packet is decoded to a one-hot queue select, taken
// from the lowest set bit of the tuser destination field. Every beat is stored
// with that select, its tlast flag and its strobe byte count in a show-ahead
// FIFO. The FIFO head is presented on registered outputs.
// Optional feature: define AXI2FIFO_DROP_EN to discard packets whose
// destination field is zero and to count them in drop_count.
module axi2fifo_param #(
    parameter int  DATA_WIDTH = 256,
    parameter int  USER_WIDTH = 128,
    parameter int  NUM_QUEUES = 8,
    parameter int  DST_OFFSET = 24,
    parameter int  DEPTH      = 16,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int CNT_W      = $clog2(STRB_W) + 1,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tvalid,
    output logic                      tready,
    input  logic [DATA_WIDTH-1:0]     tdata,
    input  logic [STRB_W-1:0]         tstrb,
    input  logic [USER_WIDTH-1:0]     tuser,
    input  logic                      tlast,
    output logic [CNT_W+DATA_WIDTH:0] dout,
    output logic                      dout_valid,
    input  logic                      output_enable,
    output logic [NUM_QUEUES-1:0]     oq,
    output logic [PTR_W:0]            fifo_count,
    output logic [15:0]               drop_count
);
    localparam int WORD_W  = 1 + CNT_W + DATA_WIDTH;
    localparam int ENTRY_W = NUM_QUEUES + WORD_W;

    typedef enum logic [1:0] {
        S_HEADER = 2'd0,
        S_BODY   = 2'd1
`ifdef AXI2FIFO_DROP_EN
        ,S_DROP  = 2'd2
`endif
    } state_t;

    // Number of asserted byte strobes; gaps in the strobe pattern are counted as-is.
    function automatic logic [CNT_W-1:0] strb_popcount(input logic [STRB_W-1:0] s);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < STRB_W; i++) begin
            c = c + CNT_W'(s[i]);
        end
        return c;
    endfunction

    state_t                  state;
    logic                    rst_done;
    logic [NUM_QUEUES-1:0]   dst;
    logic [NUM_QUEUES-1:0]   dst_low;
    logic [NUM_QUEUES-1:0]   hdr_qsel;
    logic [NUM_QUEUES-1:0]   qsel_r;
    logic [NUM_QUEUES-1:0]   wr_qsel;
    logic                    hdr_drop;
    logic                    full;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic [ENTRY_W-1:0]      wdata;
    logic [ENTRY_W-1:0]      head_next;
    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        rd_next;
    logic [PTR_W:0]          cnt_rem;
    logic [PTR_W:0]          cnt_next;
    logic                    unused_tuser;

    // Only the destination field of tuser is decoded; the rest is sideband we ignore.
    assign unused_tuser = ^tuser;

    assign dst      = tuser[DST_OFFSET +: NUM_QUEUES];
    assign dst_low  = dst & (~dst + NUM_QUEUES'(1));
    assign hdr_qsel = (dst == '0) ? NUM_QUEUES'(1) : dst_low;
    assign wr_qsel  = (state == S_HEADER) ? hdr_qsel : qsel_r;

`ifdef AXI2FIFO_DROP_EN
    assign hdr_drop = (state == S_HEADER) && (dst == '0);
    assign tready   = rst_done && ((state == S_DROP) || !full);
`else
    assign hdr_drop = 1'b0;
    assign tready   = rst_done && !full;
`endif

    assign full   = (fifo_count == (PTR_W+1)'(DEPTH));
    assign accept = tvalid && tready;
    assign push   = accept && ((state == S_BODY) || ((state == S_HEADER) && !hdr_drop));
    assign pop    = dout_valid && output_enable;
    assign wdata  = {wr_qsel, tlast, strb_popcount(tstrb), tdata};

    assign rd_next  = rd_ptr + PTR_W'(pop);
    assign cnt_rem  = fifo_count - (PTR_W+1)'(pop);
    assign cnt_next = cnt_rem + (PTR_W+1)'(push);

    // Next head word: bypass the incoming beat when the FIFO would otherwise be empty.
    always_comb begin
        head_next = mem[rd_next];
        if (cnt_rem == '0) begin
            head_next = wdata;
        end
    end

    // tready stays low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so it has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and the registered show-ahead head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
            oq         <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_next;
            fifo_count <= cnt_next;
            dout_valid <= (cnt_next != '0);
            if (cnt_next != '0) begin
                dout <= head_next[WORD_W-1:0];
                oq   <= head_next[ENTRY_W-1:WORD_W];
            end else begin
                dout <= '0;
                oq   <= '0;
            end
        end
    end

    // Packet framing FSM: decode and latch the queue on the header beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_HEADER;
            qsel_r <= '0;
        end else if (accept) begin
            case (state)
                S_HEADER: begin
                    qsel_r <= hdr_qsel;
                    if (tlast) begin
                        state <= S_HEADER;
                    end else if (hdr_drop) begin
`ifdef AXI2FIFO_DROP_EN
                        state <= S_DROP;
`else
                        state <= S_BODY;
`endif
                    end else begin
                        state <= S_BODY;
                    end
                end
                default: begin
                    if (tlast) begin
                        state <= S_HEADER;
                    end
                end
            endcase
        end
    end

`ifdef AXI2FIFO_DROP_EN
    // Saturating count of header beats whose packet is discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (accept && hdr_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_axi2fifo_param.sv
// Directed bench for axi2fifo_param with default parameters.
module tb_axi2fifo_param;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int NQ = 8;
    localparam int SW = 32;
    localparam int OW = 263;

    logic          clk           = 1'b0;
    logic          reset         = 1'b1;
    logic          tvalid        = 1'b0;
    logic          tready;
    logic [DW-1:0] tdata         = '0;
    logic [SW-1:0] tstrb         = '0;
    logic [UW-1:0] tuser         = '0;
    logic          tlast         = 1'b0;
    logic [OW-1:0] dout;
    logic          dout_valid;
    logic          output_enable = 1'b0;
    logic [NQ-1:0] oq;
    logic [4:0]    fifo_count;
    logic [15:0]   drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [OW-1:0] got_d  [$];
    logic [NQ-1:0] got_oq [$];

    always #5 clk = ~clk;

    axi2fifo_param #(
        .DATA_WIDTH(DW),
        .USER_WIDTH(UW),
        .NUM_QUEUES(NQ),
        .DST_OFFSET(24),
        .DEPTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tvalid(tvalid),
        .tready(tready),
        .tdata(tdata),
        .tstrb(tstrb),
        .tuser(tuser),
        .tlast(tlast),
        .dout(dout),
        .dout_valid(dout_valid),
        .output_enable(output_enable),
        .oq(oq),
        .fifo_count(fifo_count),
        .drop_count(drop_count)
    );

    // Record every word that will be popped at the next rising edge.
    always @(negedge clk) begin
        if (reset && dout_valid && output_enable) begin
            got_d.push_back(dout);
            got_oq.push_back(oq);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] v, input logic [SW-1:0] s,
                             input logic [NQ-1:0] dst, input logic last);
        logic acc;
        int   n;
        tvalid = 1'b1;
        tdata  = {8{v}};
        tstrb  = s;
        tuser  = '0;
        tuser[24 +: NQ] = dst;
        tlast  = last;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            acc = tready;
            step();
            n++;
        end
        check("beat_accepted", acc, 1'b1);
    endtask

    task automatic idle();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic clear_got();
        got_d.delete();
        got_oq.delete();
    endtask

    task automatic wait_words(input int n);
        int c;
        c = 0;
        while (got_d.size() < n && c < 200) begin
            step();
            c++;
        end
        check("word_count", got_d.size(), n);
    endtask

    task automatic check_word(input int idx, input logic [31:0] v, input logic [5:0] bc,
                              input logic last, input logic [NQ-1:0] exp_oq);
        logic [OW-1:0] exp_w;
        exp_w = {last, bc, {8{v}}};
        if (idx < got_d.size()) begin
            check($sformatf("word%0d", idx), got_d[idx], exp_w);
            check($sformatf("oq%0d", idx), got_oq[idx], exp_oq);
        end
    endtask

    initial begin
        int k;
        logic acc;

        // Reset: every output zero while held, tready high one cycle after release.
        #2 reset = 1'b0;
        repeat (5) step();
        check("rst_tready", tready, 1'b0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_dout", dout, '0);
        check("rst_oq", oq, '0);
        check("rst_fifo_count", fifo_count, '0);
        check("rst_drop_count", drop_count, '0);
        reset = 1'b1;
        step();
        check("post_rst_tready", tready, 1'b1);

        // 20-beat packet, dst 8'b10101111 -> queue 0, last beat 20 bytes.
        output_enable = 1'b1;
        clear_got();
        for (int i = 0; i < 20; i++) begin
            send_beat(32'(50 + i), (i == 19) ? 32'h000FFFFF : 32'hFFFFFFFF, 8'hAF, i == 19);
        end
        idle();
        wait_words(20);
        for (int i = 0; i < 20; i++) begin
            check_word(i, 32'(50 + i), (i == 19) ? 6'd20 : 6'd32, i == 19, 8'h01);
        end
        check("p1_fifo_empty", fifo_count, '0);
        check("p1_dout_valid", dout_valid, 1'b0);

        // Lowest-set-bit decode, plus write latency into an empty FIFO.
        output_enable = 1'b0;
        clear_got();
        send_beat(32'd200, 32'hFFFFFFFF, 8'hEA, 1'b0);
        check("lat_dout_valid", dout_valid, 1'b1);
        check("lat_fifo_count", fifo_count, 5'd1);
        check("lat_oq", oq, 8'h02);
        check("lat_dout", dout, {1'b0, 6'd32, {8{32'd200}}});
        send_beat(32'd201, 32'h0000000F, 8'hEA, 1'b0);
        send_beat(32'd202, 32'h00000001, 8'hEA, 1'b1);
        idle();
        check("p2_fifo_count", fifo_count, 5'd3);
        output_enable = 1'b1;
        wait_words(3);
        check_word(0, 32'd200, 6'd32, 1'b0, 8'h02);
        check_word(1, 32'd201, 6'd4, 1'b0, 8'h02);
        check_word(2, 32'd202, 6'd1, 1'b1, 8'h02);
        check("p2_fifo_empty", fifo_count, '0);

        // Backpressure: 20 beats offered with output disabled, 16 fit.
        output_enable = 1'b0;
        clear_got();
        k = 0;
        tvalid = 1'b1;
        tstrb  = '1;
        tuser  = '0;
        tuser[24 +: NQ] = 8'h04;
        for (int c = 0; c < 20; c++) begin
            tdata = {8{32'(100 + k)}};
            tlast = (k == 19);
            acc = tready;
            step();
            if (acc) k++;
        end
        check("bp_accepted", k, 16);
        check("bp_tready", tready, 1'b0);
        check("bp_fifo_count", fifo_count, 5'd16);
        // Pop while full with a beat pending: the beat must not be written.
        output_enable = 1'b1;
        step();
        check("bp_full_pop_count", fifo_count, 5'd15);
        send_beat(32'd116, 32'hFFFFFFFF, 8'h04, 1'b0);
        check("bp_push_pop_count", fifo_count, 5'd15);
        for (int i = 17; i < 20; i++) begin
            send_beat(32'(100 + i), 32'hFFFFFFFF, 8'h04, i == 19);
        end
        idle();
        wait_words(20);
        for (int i = 0; i < 20; i++) begin
            check_word(i, 32'(100 + i), 6'd32, i == 19, 8'h04);
        end
        check("bp_fifo_empty", fifo_count, '0);

        // Destination zero: dropped when the feature is built in, else queue 0.
        clear_got();
`ifdef AXI2FIFO_DROP_EN
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drop_tready%0d", i), tready, 1'b1);
            send_beat(32'(300 + i), 32'hFFFFFFFF, 8'h00, i == 4);
        end
        idle();
        check("drop_count", drop_count, 16'd1);
        check("drop_fifo_count", fifo_count, '0);
        send_beat(32'd400, 32'hFFFFFFFF, 8'h04, 1'b0);
        send_beat(32'd401, 32'hFFFFFFFF, 8'h04, 1'b1);
        idle();
        wait_words(2);
        check_word(0, 32'd400, 6'd32, 1'b0, 8'h04);
        check_word(1, 32'd401, 6'd32, 1'b1, 8'h04);
`else
        send_beat(32'd300, 32'hFFFFFFFF, 8'h00, 1'b0);
        send_beat(32'd301, 32'hFFFFFFFF, 8'h00, 1'b1);
        idle();
        wait_words(2);
        check_word(0, 32'd300, 6'd32, 1'b0, 8'h01);
        check_word(1, 32'd301, 6'd32, 1'b1, 8'h01);
        check("nodrop_count", drop_count, 16'd0);
`endif

        // Reset after beat 3 of a 10-beat packet; remainder decoded as a header.
        output_enable = 1'b0;
        clear_got();
        for (int i = 0; i < 3; i++) begin
            send_beat(32'(500 + i), 32'hFFFFFFFF, 8'h08, 1'b0);
        end
        check("mid_fifo_count", fifo_count, 5'd3);
        reset = 1'b0;
        #1;
        check("mid_rst_fifo_count", fifo_count, '0);
        check("mid_rst_dout_valid", dout_valid, 1'b0);
        check("mid_rst_tready", tready, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        check("mid_rel_tready", tready, 1'b1);
        check("mid_rel_fifo_count", fifo_count, '0);
        check("mid_rel_dout_valid", dout_valid, 1'b0);
        check("mid_rel_dout", dout, '0);
        check("mid_rel_drop_count", drop_count, '0);
        for (int i = 3; i < 10; i++) begin
            send_beat(32'(500 + i), 32'hFFFFFFFF, 8'h30, i == 9);
        end
        idle();
        check("mid_new_count", fifo_count, 5'd7);
        output_enable = 1'b1;
        wait_words(7);
        for (int i = 0; i < 7; i++) begin
            check_word(i, 32'(503 + i), 6'd32, i == 6, 8'h10);
        end
        check("mid_fifo_empty", fifo_count, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
